// File: rtl/ifc_driver_pkg.sv
// Purpose : shared types and constants for the ifc_driver block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package ifc_driver_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Result sum width; 255 samples of 255 cannot overflow it.
    localparam int SUM_W = 16;

    // Legal SETTLE range and the width of the settle counter.
    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 15;
    localparam int SETTLE_CW  = 4;

endpackage

// File: rtl/ifc_drv_acc.sv
// Purpose : accumulates responder samples into SUM / XOR / N.
// Latency : 1 cycle from clr/upd to registered outputs.
// Backpressure: none; the parent decides when to clear or update.
// Ports   : clk, rst (sync, active-high), clr (start of command), upd (sample edge),
//           z (sampled response), sum/xr/n (registered accumulator state).
module ifc_drv_acc
    import ifc_driver_pkg::*;
#(
    parameter int QW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             upd,
    input  logic [QW-1:0]    z,
    output logic [SUM_W-1:0] sum,
    output logic [QW-1:0]    xr,
    output logic [7:0]       n
);

    logic [SUM_W-1:0] sum_q, sum_d;
    logic [QW-1:0]    xr_q, xr_d;
    logic [7:0]       n_q, n_d;

    always_comb begin
        sum_d = sum_q;
        xr_d  = xr_q;
        n_d   = n_q;
        if (clr) begin
            sum_d = '0;
            xr_d  = '0;
            n_d   = '0;
        end else if (upd) begin
            sum_d = sum_q + SUM_W'(z);
            xr_d  = xr_q ^ z;
            n_d   = n_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            xr_q  <= '0;
            n_q   <= '0;
        end else begin
            sum_q <= sum_d;
            xr_q  <= xr_d;
            n_q   <= n_d;
        end
    end

    assign sum = sum_q;
    assign xr  = xr_q;
    assign n   = n_q;

endmodule

// File: rtl/ifc_driver.sv
// Purpose : drives COUNT X/Y/Q transactions at a responder, holding each for
//           SETTLE cycles, and returns SUM/XOR/N of the sampled IFC_Z values.
// Latency : COUNT*SETTLE+1 cycles from command accept to RES_VALID.
// Backpressure: CMD_READY only in IDLE; result held in DONE until RES_READY.
// Ports   : CMD_* command handshake, IFC_* responder interface (IFC_Z comb. input),
//           RES_* result handshake; CLK with synchronous active-high RST.
module ifc_driver
    import ifc_driver_pkg::*;
#(
    parameter int XW     = 16,
    parameter int QW     = 8,
    parameter int SETTLE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [XW-1:0]    CMD_X,
    input  logic [XW-1:0]    CMD_Y,
    input  logic [QW-1:0]    CMD_Q,
    input  logic [7:0]       CMD_COUNT,
    output logic [XW-1:0]    IFC_X,
    output logic [XW-1:0]    IFC_Y,
    output logic [QW-1:0]    IFC_Q,
    output logic             IFC_STB,
    input  logic [QW-1:0]    IFC_Z,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [SUM_W-1:0] RES_SUM,
    output logic [QW-1:0]    RES_XOR,
    output logic [7:0]       RES_N
);

    // Out-of-range SETTLE values are clamped into the counter's legal range.
    localparam int SETTLE_CLAMP = (SETTLE < SETTLE_MIN) ? SETTLE_MIN :
                                  (SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE;
    localparam logic [SETTLE_CW-1:0] SETTLE_INIT = SETTLE_CW'(SETTLE_CLAMP);

    state_t               state_q, state_d;
    logic [SETTLE_CW-1:0] settle_q, settle_d;
    logic [7:0]           remaining_q, remaining_d;
    logic [XW-1:0]        ifc_x_q, ifc_x_d;
    logic [XW-1:0]        ifc_y_q, ifc_y_d;
    logic [QW-1:0]        ifc_q_q, ifc_q_d;
    logic                 acc_clr;
    logic                 acc_upd;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        remaining_d = remaining_q;
        ifc_x_d     = ifc_x_q;
        ifc_y_d     = ifc_y_q;
        ifc_q_d     = ifc_q_q;
        acc_clr     = 1'b0;
        acc_upd     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    ifc_x_d     = CMD_X;
                    ifc_y_d     = CMD_Y;
                    ifc_q_d     = CMD_Q;
                    remaining_d = CMD_COUNT;
                    settle_d    = SETTLE_INIT;
                    acc_clr     = 1'b1;
                    state_d     = (CMD_COUNT != 8'd0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (settle_q == SETTLE_CW'(1)) begin
                    // Sample edge: IFC_Z reflects the fields held this window.
                    acc_upd     = 1'b1;
                    ifc_x_d     = ifc_x_q - XW'(ifc_q_q);
                    ifc_y_d     = ifc_y_q + XW'(1);
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d = S_DONE;
                    end else begin
                        settle_d = SETTLE_INIT;
                    end
                end else begin
                    settle_d = settle_q - SETTLE_CW'(1);
                end
            end
            S_DONE: begin
                if (RES_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            settle_q    <= '0;
            remaining_q <= '0;
            ifc_x_q     <= '0;
            ifc_y_q     <= '0;
            ifc_q_q     <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            remaining_q <= remaining_d;
            ifc_x_q     <= ifc_x_d;
            ifc_y_q     <= ifc_y_d;
            ifc_q_q     <= ifc_q_d;
        end
    end

    ifc_drv_acc #(
        .QW (QW)
    ) u_acc (
        .clk (CLK),
        .rst (RST),
        .clr (acc_clr),
        .upd (acc_upd),
        .z   (IFC_Z),
        .sum (RES_SUM),
        .xr  (RES_XOR),
        .n   (RES_N)
    );

    assign CMD_READY = (state_q == S_IDLE);
    assign IFC_STB   = (state_q == S_WAIT);
    assign RES_VALID = (state_q == S_DONE);
    assign IFC_X     = ifc_x_q;
    assign IFC_Y     = ifc_y_q;
    assign IFC_Q     = ifc_q_q;

endmodule

// File: tb/tb_ifc_driver.sv
module tb_ifc_driver;

    typedef struct packed {
        logic [15:0] sum;
        logic [7:0]  xr;
        logic [7:0]  n;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_x = '0, cmd_y = '0;
    logic [7:0]  cmd_q = '0, cmd_count = '0;
    logic        res_ready = 1'b0;

    logic        a_ready, a_stb, a_vld, b_ready, b_stb, b_vld;
    logic [15:0] a_x, a_y, a_sum, b_x, b_y, b_sum;
    logic [7:0]  a_q, a_xor, a_n, b_q, b_xor, b_n;
    logic [7:0]  a_z;
    logic [7:0]  b_z = 8'hFF;
    logic [15:0] a_full, b_full;
    int          b_cnt = 0;

    ifc_driver #(.XW(16), .QW(8), .SETTLE(1)) u_dut_a (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid & ~sel), .CMD_READY(a_ready),
        .CMD_X(cmd_x), .CMD_Y(cmd_y), .CMD_Q(cmd_q), .CMD_COUNT(cmd_count),
        .IFC_X(a_x), .IFC_Y(a_y), .IFC_Q(a_q), .IFC_STB(a_stb), .IFC_Z(a_z),
        .RES_VALID(a_vld), .RES_READY(res_ready & ~sel),
        .RES_SUM(a_sum), .RES_XOR(a_xor), .RES_N(a_n)
    );

    ifc_driver #(.XW(16), .QW(8), .SETTLE(3)) u_dut_b (
        .CLK(clk), .RST(rst), .CMD_VALID(cmd_valid & sel), .CMD_READY(b_ready),
        .CMD_X(cmd_x), .CMD_Y(cmd_y), .CMD_Q(cmd_q), .CMD_COUNT(cmd_count),
        .IFC_X(b_x), .IFC_Y(b_y), .IFC_Q(b_q), .IFC_STB(b_stb), .IFC_Z(b_z),
        .RES_VALID(b_vld), .RES_READY(res_ready & sel),
        .RES_SUM(b_sum), .RES_XOR(b_xor), .RES_N(b_n)
    );

    // Responder: Z = (X+Y-Q) truncated. The SETTLE=3 responder glitches on
    // every strobe cycle except the last of each 3-cycle window.
    assign a_full = a_x + a_y - {8'd0, a_q};
    assign a_z    = a_full[7:0];
    assign b_full = b_x + b_y - {8'd0, b_q};

    always @(negedge clk) begin
        if (b_stb) begin
            b_cnt = b_cnt + 1;
            b_z   = (b_cnt % 3 == 0) ? b_full[7:0] : (b_full[7:0] ^ 8'h5A);
        end else begin
            b_cnt = 0;
            b_z   = 8'hFF;
        end
    end

    logic        o_ready, o_stb, o_vld;
    logic [15:0] o_x, o_y, o_sum;
    logic [7:0]  o_q, o_xor, o_n;
    assign o_ready = sel ? b_ready : a_ready;
    assign o_stb   = sel ? b_stb   : a_stb;
    assign o_vld   = sel ? b_vld   : a_vld;
    assign o_x     = sel ? b_x     : a_x;
    assign o_y     = sel ? b_y     : a_y;
    assign o_q     = sel ? b_q     : a_q;
    assign o_sum   = sel ? b_sum   : a_sum;
    assign o_xor   = sel ? b_xor   : a_xor;
    assign o_n     = sel ? b_n     : a_n;

    res_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] xs [0:15];
    int          stb_cycles;
    int          lat;

    function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic [7:0] q, input logic [7:0] cnt);
        res_t        r;
        logic [15:0] t;
        r = '0;
        for (int i = 0; i < int'(cnt); i++) begin
            t     = x + y - {8'd0, q};
            r.sum = r.sum + {8'd0, t[7:0]};
            r.xr  = r.xr ^ t[7:0];
            x     = x - {8'd0, q};
            y     = y + 16'd1;
        end
        r.n = cnt;
        return r;
    endfunction

    // Issue one command, push its expected result, then wait for RES_VALID.
    task automatic issue(input logic s, input logic [15:0] x, input logic [15:0] y,
                         input logic [7:0] q, input logic [7:0] cnt);
        @(negedge clk);
        sel = s; cmd_x = x; cmd_y = y; cmd_q = q; cmd_count = cnt; cmd_valid = 1'b1;
        vectors++;
        if (o_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_ready_idle: got %b want 1", o_ready);
        end
        sb_q.push_back(model(x, y, q, cnt));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        stb_cycles = 0;
        do begin
            @(negedge clk);
            lat++;
            if (o_stb) begin
                if (stb_cycles < 16) xs[stb_cycles] = o_x;
                stb_cycles++;
            end
        end while (!o_vld && lat < 2000);
        vectors++;
        if (o_vld !== 1'b1) begin
            miscompares++;
            $display("FAIL res_timeout: res_valid got %b want 1 within 2000 cycles", o_vld);
        end
    endtask

    task automatic check_result(input string tag);
        res_t e;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: result seen, scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            if ({o_sum, o_xor, o_n} !== e) begin
                miscompares++;
                $display("FAIL %s: got sum=%h xor=%h n=%0d want sum=%h xor=%h n=%0d",
                         tag, o_sum, o_xor, o_n, e.sum, e.xr, e.n);
            end
        end
    endtask

    task automatic consume();
        @(negedge clk);
        res_ready = 1'b1;
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_on_consume: got %b want 0", o_ready);
        end
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({o_ready, o_vld} !== 2'b10) begin
            miscompares++;
            $display("FAIL ready_after_consume: got ready,vld=%b want 10", {o_ready, o_vld});
        end
    endtask

    task automatic check_idle_zero(input string tag);
        vectors++;
        if ({o_ready, o_vld, o_stb} !== 3'b100) begin
            miscompares++;
            $display("FAIL %s_status: got ready,vld,stb=%b want 100", tag, {o_ready, o_vld, o_stb});
        end
        vectors++;
        if ({o_x, o_y, o_q, o_sum, o_xor, o_n} !== 72'd0) begin
            miscompares++;
            $display("FAIL %s_outputs: got x=%h y=%h q=%h sum=%h xor=%h n=%h want all 0",
                     tag, o_x, o_y, o_q, o_sum, o_xor, o_n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
    endtask

    task automatic test_basic();
        issue(1'b0, 16'd17, 16'd21, 8'd3, 8'd2);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d want 3", lat);
        end
        vectors++;
        if (stb_cycles !== 2) begin
            miscompares++;
            $display("FAIL basic_stb_cycles: got %0d want 2", stb_cycles);
        end
        vectors++;
        if ({xs[0], xs[1]} !== {16'd17, 16'd14}) begin
            miscompares++;
            $display("FAIL basic_ifc_x: got %0d,%0d want 17,14", xs[0], xs[1]);
        end
        check_result("basic_result");
        consume();
    endtask

    task automatic test_zero_count();
        issue(1'b0, 16'd5, 16'd6, 8'd7, 8'd0);
        vectors++;
        if (lat !== 1 || stb_cycles !== 0) begin
            miscompares++;
            $display("FAIL zero_timing: got lat=%0d stb=%0d want lat=1 stb=0", lat, stb_cycles);
        end
        check_result("zero_result");
        consume();
    endtask

    task automatic test_wrap();
        issue(1'b0, 16'd2, 16'd0, 8'd3, 8'd2);
        vectors++;
        if (xs[1] !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_ifc_x: got %h want ffff", xs[1]);
        end
        check_result("wrap_result");
        consume();
    endtask

    task automatic test_settle();
        issue(1'b1, 16'd17, 16'd21, 8'd3, 8'd2);
        vectors++;
        if (stb_cycles !== 6 || lat !== 7) begin
            miscompares++;
            $display("FAIL settle_timing: got stb=%0d lat=%0d want stb=6 lat=7", stb_cycles, lat);
        end
        check_result("settle_result");
        consume();
        sel = 1'b0;
    endtask

    task automatic test_hold();
        res_t e;
        issue(1'b0, 16'd100, 16'd200, 8'd7, 8'd3);
        e = sb_q[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({o_vld, o_ready, o_sum, o_xor, o_n} !== {2'b10, e}) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got vld=%b ready=%b sum=%h xor=%h n=%0d want 1 0 %h %h %0d",
                         i, o_vld, o_ready, o_sum, o_xor, o_n, e.sum, e.xr, e.n);
            end
        end
        check_result("hold_result");
        consume();
    endtask

    task automatic test_reset_mid();
        int seen_vld;
        @(negedge clk);
        sel = 1'b0; cmd_x = 16'd9; cmd_y = 16'd4; cmd_q = 8'd1; cmd_count = 8'd5;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (o_stb !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_in_wait: stb got %b want 1", o_stb);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_zero("rstmid");
        seen_vld = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (o_vld) seen_vld++;
        end
        vectors++;
        if (seen_vld !== 0) begin
            miscompares++;
            $display("FAIL rstmid_no_result: res_valid cycles got %0d want 0", seen_vld);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cnt;
        for (int i = 0; i < 6; i++) begin
            cnt = 8'($urandom_range(0, 4));
            issue(1'b0, 16'($urandom), 16'($urandom), 8'($urandom), cnt);
            vectors++;
            if (lat !== int'(cnt) + 1) begin
                miscompares++;
                $display("FAIL b2b_latency%0d: got %0d want %0d", i, lat, int'(cnt) + 1);
            end
            check_result("b2b_result");
            consume();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_wrap();
        test_settle();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
